// File: rtl/monitor_pkg.sv
// Shared types and defaults for the counter monitor: sample width and the
// motion/alarm encodings seen on the direcao and estado outputs.
package monitor_pkg;

    localparam int LARG_PADRAO = 8;

    typedef enum logic [1:0] {
        DIR_PARADO = 2'b00,
        DIR_SOBE   = 2'b01,
        DIR_DESCE  = 2'b10,
        DIR_SALTO  = 2'b11
    } direcao_t;

    typedef enum logic [1:0] {
        EST_NORMAL = 2'b00,
        EST_PRE    = 2'b01,
        EST_ALTO   = 2'b10,
        EST_BAIXO  = 2'b11
    } estado_t;

endpackage

// File: rtl/monitor_contagem_rastreador_extremos.sv
// Tracks the largest and smallest sample since reset or limpar; the first
// sample after either loads both extremes.
module rastreador_extremos
    import monitor_pkg::*;
#(
    parameter int LARG = LARG_PADRAO
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            limpar,
    input  logic [LARG-1:0] amostra,
    output logic [LARG-1:0] val_max,
    output logic [LARG-1:0] val_min
);

    localparam logic [LARG-1:0] ZERO     = {LARG{1'b0}};
    localparam logic [LARG-1:0] TODOS_UM = {LARG{1'b1}};

    logic [LARG-1:0] max_q, max_d;
    logic [LARG-1:0] min_q, min_d;
    logic            vazio_q, vazio_d;

    // Next-extreme selection: clear, first-sample load, or running compare.
    always_comb begin
        max_d   = max_q;
        min_d   = min_q;
        vazio_d = vazio_q;
        if (limpar) begin
            max_d   = ZERO;
            min_d   = TODOS_UM;
            vazio_d = 1'b1;
        end else if (vazio_q) begin
            max_d   = amostra;
            min_d   = amostra;
            vazio_d = 1'b0;
        end else begin
            if (amostra > max_q) begin
                max_d = amostra;
            end else begin
                max_d = max_q;
            end
            if (amostra < min_q) begin
                min_d = amostra;
            end else begin
                min_d = min_q;
            end
        end
    end

    // Extreme registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q   <= ZERO;
            min_q   <= TODOS_UM;
            vazio_q <= 1'b1;
        end else begin
            max_q   <= max_d;
            min_q   <= min_d;
            vazio_q <= vazio_d;
        end
    end

    assign val_max = max_q;
    assign val_min = min_q;

endmodule

// File: rtl/monitor_contagem.sv
// Watches an up/down counter output: infers motion, counts wraps, tracks
// extremes and runs a two-step confirmed high/low alarm.
module monitor_contagem
    import monitor_pkg::*;
#(
    parameter int LARG = LARG_PADRAO
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            limpar,
    input  logic [LARG-1:0] contagem_in,
    input  logic [LARG-1:0] lim_alto,
    input  logic [LARG-1:0] lim_baixo,
    output logic [1:0]      direcao,
    output logic            wrap_pulso,
    output logic [LARG-1:0] num_wraps,
    output logic [1:0]      estado,
    output logic            erro_cfg,
    output logic [LARG-1:0] val_max,
    output logic [LARG-1:0] val_min
);

    localparam logic [LARG-1:0] ZERO     = {LARG{1'b0}};
    localparam logic [LARG-1:0] UM       = {{(LARG-1){1'b0}}, 1'b1};
    localparam logic [LARG-1:0] TODOS_UM = {LARG{1'b1}};

    logic [LARG-1:0] anterior_q, anterior_d;
    logic            valido_q, valido_d;
    direcao_t        direcao_q, direcao_d;
    logic            wrap_q, wrap_d;
    logic [LARG-1:0] num_wraps_q, num_wraps_d;
    estado_t         estado_q, estado_d;
    logic            lado_alto_q, lado_alto_d;

    logic [LARG-1:0] delta_s;
    logic            wrap_s;
    logic            acima_s;
    logic            abaixo_s;
    logic            erro_cfg_s;

    assign delta_s    = contagem_in - anterior_q;
    assign wrap_s     = ((anterior_q == TODOS_UM) && (contagem_in == ZERO)) ||
                        ((anterior_q == ZERO) && (contagem_in == TODOS_UM));
    assign acima_s    = (contagem_in >= lim_alto);
    assign abaixo_s   = (contagem_in <= lim_baixo);
    assign erro_cfg_s = (lim_baixo >= lim_alto);

    // Sample history, motion classification and wrap counting.
    always_comb begin
        anterior_d  = anterior_q;
        valido_d    = valido_q;
        direcao_d   = direcao_q;
        wrap_d      = wrap_q;
        num_wraps_d = num_wraps_q;
        if (limpar) begin
            valido_d    = 1'b0;
            direcao_d   = DIR_PARADO;
            wrap_d      = 1'b0;
            num_wraps_d = ZERO;
        end else begin
            anterior_d = contagem_in;
            valido_d   = 1'b1;
            if (valido_q) begin
                if (delta_s == ZERO) begin
                    direcao_d = DIR_PARADO;
                end else if (delta_s == UM) begin
                    direcao_d = DIR_SOBE;
                end else if (delta_s == TODOS_UM) begin
                    direcao_d = DIR_DESCE;
                end else begin
                    direcao_d = DIR_SALTO;
                end
                wrap_d = wrap_s;
                if (wrap_s && (num_wraps_q != TODOS_UM)) begin
                    num_wraps_d = num_wraps_q + UM;
                end else begin
                    num_wraps_d = num_wraps_q;
                end
            end else begin
                direcao_d = DIR_PARADO;
                wrap_d    = 1'b0;
            end
        end
    end

    // Alarm next state; lado_alto remembers which side armed PRE.
    always_comb begin
        estado_d    = estado_q;
        lado_alto_d = lado_alto_q;
        if (limpar || !valido_q || erro_cfg_s) begin
            estado_d = EST_NORMAL;
        end else begin
            case (estado_q)
                EST_NORMAL: begin
                    if (acima_s) begin
                        estado_d    = EST_PRE;
                        lado_alto_d = 1'b1;
                    end else if (abaixo_s) begin
                        estado_d    = EST_PRE;
                        lado_alto_d = 1'b0;
                    end else begin
                        estado_d = EST_NORMAL;
                    end
                end
                EST_PRE: begin
                    if (lado_alto_q && acima_s) begin
                        estado_d = EST_ALTO;
                    end else if (!lado_alto_q && abaixo_s) begin
                        estado_d = EST_BAIXO;
                    end else begin
                        estado_d = EST_NORMAL;
                    end
                end
                EST_ALTO: begin
                    if (abaixo_s) begin
                        estado_d    = EST_PRE;
                        lado_alto_d = 1'b0;
                    end else if (!acima_s) begin
                        estado_d = EST_NORMAL;
                    end else begin
                        estado_d = EST_ALTO;
                    end
                end
                EST_BAIXO: begin
                    if (acima_s) begin
                        estado_d    = EST_PRE;
                        lado_alto_d = 1'b1;
                    end else if (!abaixo_s) begin
                        estado_d = EST_NORMAL;
                    end else begin
                        estado_d = EST_BAIXO;
                    end
                end
                default: begin
                    estado_d = EST_NORMAL;
                end
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anterior_q  <= ZERO;
            valido_q    <= 1'b0;
            direcao_q   <= DIR_PARADO;
            wrap_q      <= 1'b0;
            num_wraps_q <= ZERO;
        end else begin
            anterior_q  <= anterior_d;
            valido_q    <= valido_d;
            direcao_q   <= direcao_d;
            wrap_q      <= wrap_d;
            num_wraps_q <= num_wraps_d;
        end
    end

    // Alarm state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q    <= EST_NORMAL;
            lado_alto_q <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            lado_alto_q <= lado_alto_d;
        end
    end

    rastreador_extremos #(
        .LARG (LARG)
    ) u_extremos (
        .clk     (clk),
        .rst_n   (rst_n),
        .limpar  (limpar),
        .amostra (contagem_in),
        .val_max (val_max),
        .val_min (val_min)
    );

    assign direcao    = direcao_q;
    assign wrap_pulso = wrap_q;
    assign num_wraps  = num_wraps_q;
    assign estado     = estado_q;
    assign erro_cfg   = erro_cfg_s;

endmodule

// File: tb/tb_monitor_contagem.sv
// Directed bench for monitor_contagem with hand-computed expectations.
module tb_monitor_contagem;

    logic       clk;
    logic       rst_n;
    logic       limpar;
    logic [7:0] contagem_in;
    logic [7:0] lim_alto;
    logic [7:0] lim_baixo;
    logic [1:0] direcao;
    logic       wrap_pulso;
    logic [7:0] num_wraps;
    logic [1:0] estado;
    logic       erro_cfg;
    logic [7:0] val_max;
    logic [7:0] val_min;

    int checks_q   = 0;
    int failures_q = 0;

    monitor_contagem #(.LARG(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .limpar      (limpar),
        .contagem_in (contagem_in),
        .lim_alto    (lim_alto),
        .lim_baixo   (lim_baixo),
        .direcao     (direcao),
        .wrap_pulso  (wrap_pulso),
        .num_wraps   (num_wraps),
        .estado      (estado),
        .erro_cfg    (erro_cfg),
        .val_max     (val_max),
        .val_min     (val_min)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_q = checks_q + 1;
        if (obs !== exp) begin
            failures_q = failures_q + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic amostra(input logic [7:0] v);
        contagem_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk_val({tag, "_dir"},  {30'd0, direcao}, 32'd0);
        chk_val({tag, "_wrap"}, {31'd0, wrap_pulso}, 32'd0);
        chk_val({tag, "_nw"},   {24'd0, num_wraps}, 32'd0);
        chk_val({tag, "_est"},  {30'd0, estado}, 32'd0);
        chk_val({tag, "_max"},  {24'd0, val_max}, 32'd0);
        chk_val({tag, "_min"},  {24'd0, val_min}, 32'd255);
    endtask

    initial begin
        rst_n       = 1'b0;
        limpar      = 1'b0;
        contagem_in = 8'd0;
        lim_alto    = 8'd200;
        lim_baixo   = 8'd20;
        #12;
        chk_reset("rst");
        chk_val("rst_erro", {31'd0, erro_cfg}, 32'd0);
        rst_n = 1'b1;

        // ramp 9,10,11
        amostra(8'd9);
        chk_val("ramp0_dir", {30'd0, direcao}, 32'd0);
        chk_val("ramp0_max", {24'd0, val_max}, 32'd9);
        chk_val("ramp0_min", {24'd0, val_min}, 32'd9);
        amostra(8'd10);
        chk_val("ramp1_dir", {30'd0, direcao}, 32'd1);
        amostra(8'd11);
        chk_val("ramp2_dir", {30'd0, direcao}, 32'd1);
        chk_val("ramp2_max", {24'd0, val_max}, 32'd11);
        chk_val("ramp2_min", {24'd0, val_min}, 32'd9);

        // up wrap 254,255,0,1
        amostra(8'd254);
        chk_val("up0_dir",  {30'd0, direcao}, 32'd3);
        chk_val("up0_est",  {30'd0, estado}, 32'd1);
        amostra(8'd255);
        chk_val("up1_dir",  {30'd0, direcao}, 32'd1);
        chk_val("up1_wrap", {31'd0, wrap_pulso}, 32'd0);
        chk_val("up1_est",  {30'd0, estado}, 32'd2);
        amostra(8'd0);
        chk_val("up2_dir",  {30'd0, direcao}, 32'd1);
        chk_val("up2_wrap", {31'd0, wrap_pulso}, 32'd1);
        chk_val("up2_nw",   {24'd0, num_wraps}, 32'd1);
        chk_val("up2_est",  {30'd0, estado}, 32'd1);
        amostra(8'd1);
        chk_val("up3_dir",  {30'd0, direcao}, 32'd1);
        chk_val("up3_wrap", {31'd0, wrap_pulso}, 32'd0);
        chk_val("up3_est",  {30'd0, estado}, 32'd3);

        // down wrap 1,0,255,254
        amostra(8'd1);
        chk_val("dn0_dir",  {30'd0, direcao}, 32'd0);
        amostra(8'd0);
        chk_val("dn1_dir",  {30'd0, direcao}, 32'd2);
        chk_val("dn1_wrap", {31'd0, wrap_pulso}, 32'd0);
        amostra(8'd255);
        chk_val("dn2_dir",  {30'd0, direcao}, 32'd2);
        chk_val("dn2_wrap", {31'd0, wrap_pulso}, 32'd1);
        chk_val("dn2_nw",   {24'd0, num_wraps}, 32'd2);
        chk_val("dn2_est",  {30'd0, estado}, 32'd1);
        amostra(8'd254);
        chk_val("dn3_dir",  {30'd0, direcao}, 32'd2);
        chk_val("dn3_wrap", {31'd0, wrap_pulso}, 32'd0);
        chk_val("dn3_est",  {30'd0, estado}, 32'd2);
        chk_val("dn3_max",  {24'd0, val_max}, 32'd255);
        chk_val("dn3_min",  {24'd0, val_min}, 32'd0);

        // alarm sequence 199,200,201,150
        amostra(8'd100);
        chk_val("al_norm", {30'd0, estado}, 32'd0);
        amostra(8'd199);
        chk_val("al199", {30'd0, estado}, 32'd0);
        amostra(8'd200);
        chk_val("al200", {30'd0, estado}, 32'd1);
        amostra(8'd201);
        chk_val("al201", {30'd0, estado}, 32'd2);
        amostra(8'd150);
        chk_val("al150", {30'd0, estado}, 32'd0);

        // limpar then load jump 50 -> 9
        limpar = 1'b1;
        amostra(8'd150);
        limpar = 1'b0;
        chk_val("clr_nw",  {24'd0, num_wraps}, 32'd0);
        chk_val("clr_max", {24'd0, val_max}, 32'd0);
        chk_val("clr_min", {24'd0, val_min}, 32'd255);
        chk_val("clr_dir", {30'd0, direcao}, 32'd0);
        amostra(8'd50);
        chk_val("ld0_dir", {30'd0, direcao}, 32'd0);
        chk_val("ld0_max", {24'd0, val_max}, 32'd50);
        chk_val("ld0_min", {24'd0, val_min}, 32'd50);
        amostra(8'd9);
        chk_val("ld1_dir", {30'd0, direcao}, 32'd3);
        chk_val("ld1_min", {24'd0, val_min}, 32'd9);
        chk_val("ld1_est", {30'd0, estado}, 32'd1);

        // bad configuration forces NORMAL
        lim_baixo = 8'd200;
        lim_alto  = 8'd100;
        #1;
        chk_val("cfg_erro", {31'd0, erro_cfg}, 32'd1);
        amostra(8'd250);
        chk_val("cfg_est0", {30'd0, estado}, 32'd0);
        amostra(8'd250);
        chk_val("cfg_est1", {30'd0, estado}, 32'd0);
        lim_baixo = 8'd100;
        #1;
        chk_val("cfg_eq", {31'd0, erro_cfg}, 32'd1);
        lim_baixo = 8'd20;
        lim_alto  = 8'd200;
        #1;
        chk_val("cfg_ok", {31'd0, erro_cfg}, 32'd0);

        // saturating wrap count
        amostra(8'd255);
        for (int i = 0; i < 300; i++) begin
            amostra((i % 2 == 0) ? 8'd0 : 8'd255);
            if (i == 253) chk_val("sat254", {24'd0, num_wraps}, 32'd254);
            if (i == 254) chk_val("sat255", {24'd0, num_wraps}, 32'd255);
        end
        chk_val("sat_end", {24'd0, num_wraps}, 32'd255);

        // reset in the middle of ALTO
        amostra(8'd100);
        amostra(8'd100);
        amostra(8'd210);
        chk_val("mid_pre", {30'd0, estado}, 32'd1);
        amostra(8'd210);
        chk_val("mid_alto", {30'd0, estado}, 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset("arst");
        #10;
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks_q, failures_q);
        $finish;
    end

endmodule

// File: doc/monitor_contagem.md
MONITOR_CONTAGEM -- requirements
Module: monitor_contagem

Interface
REQ-001 Parameter LARG, default 8, data width of counter sample and limits.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; reset asserts immediately, deassert synchronous to clock.
REQ-004 limpar  input  1  synchronous clear of statistics (wraps, max, min, first-sample flag).
REQ-005 contagem_in  input  LARG  counter_out of upstream 8-bit up/down counter, sampled every cycle.
REQ-006 lim_alto  input  LARG  upper alarm threshold.
REQ-007 lim_baixo  input  LARG  lower alarm threshold.
REQ-008 direcao  output  2  inferred motion: 00 parado, 01 sobe, 10 desce, 11 salto.
REQ-009 wrap_pulso  output  1  one-cycle pulse on 255->0 or 0->255 transition.
REQ-010 num_wraps  output  LARG  saturating count of wraps.
REQ-011 estado  output  2  alarm FSM state: 00 NORMAL, 01 PRE, 10 ALTO, 11 BAIXO.
REQ-012 erro_cfg  output  1  high while lim_baixo >= lim_alto.
REQ-013 val_max / val_min  output  LARG each  extremes seen since reset/limpar.

Function
REQ-014 Block SHALL register contagem_in into anterior each cycle; valido flag SHALL set one cycle after first sample post-reset/limpar.
REQ-015 While valido=0, direcao SHALL be 00, wrap_pulso 0, FSM held NORMAL.
REQ-016 delta = contagem_in - anterior modulo 2^LARG; delta 0 -> 00, 1 -> 01, all-ones -> 10, any other -> 11 (load jump).
REQ-017 direcao, wrap_pulso SHALL be registered: visible one cycle after the sample pair that caused them.
REQ-018 Wrap SHALL be detected when anterior=255 and contagem_in=0 (up) or anterior=0 and contagem_in=255 (down); direcao for these SHALL be 01 and 10 respectively.
REQ-019 num_wraps SHALL increment by 1 per wrap and saturate at 255, never roll over.
REQ-020 val_max/val_min SHALL update same cycle as sample registration; first valid sample loads both.
REQ-021 FSM: NORMAL -> PRE when sample >= lim_alto or <= lim_baixo; PRE -> ALTO/BAIXO if next sample qualifies on same side; PRE -> NORMAL otherwise.
REQ-022 ALTO -> NORMAL when sample < lim_alto; BAIXO -> NORMAL when sample > lim_baixo; ALTO<->BAIXO direct transition SHALL pass through PRE.
REQ-023 When erro_cfg=1, FSM SHALL be forced to NORMAL and held there; erro_cfg is combinational from limits.
REQ-024 limpar SHALL have priority over sample update in the same cycle; it SHALL not change direcao encoding beyond REQ-015.

Reset
REQ-025 On reset low: anterior=0, valido=0, direcao=00, wrap_pulso=0, num_wraps=0, estado=NORMAL, val_max=0, val_min=255.
REQ-026 Reset mid-alarm SHALL drop estado to NORMAL immediately (asynchronous).

Structure
REQ-027 Package monitor_pkg SHALL hold LARG default, direcao enum, FSM state enum and their encodings.
REQ-028 One sub-module rastreador_extremos SHALL implement val_max/val_min with limpar and first-sample load.
REQ-029 Total RTL 120-400 lines; no latches; all outputs registered except erro_cfg.

Verification
REQ-030 Reset released, input ramps 9,10,11 -> direcao 01 from 2nd cycle after first sample, val_min=9, val_max=11.
REQ-031 Input 254,255,0,1 -> one wrap_pulso cycle, num_wraps=1, direcao 01 throughout.
REQ-032 Input 1,0,255,254 -> wrap_pulso once, direcao 10, num_wraps increments.
REQ-033 lim_alto=200, lim_baixo=20; input 199,200,201,150 -> estado NORMAL,PRE,ALTO,NORMAL at successive cycles.
REQ-034 Input 50 then 9 (load) -> direcao 11; set lim_baixo=200, lim_alto=100 -> erro_cfg=1, estado stays NORMAL.
REQ-035 300 consecutive wraps -> num_wraps holds 255; reset asserted mid-ALTO -> all outputs at REQ-025 values same cycle.
